pe_rx_frame: RTL and testbench
==============================

# pe_rx_frame

Receive-side endpoint for the PE array output stream, the counterpart of the simulation input driver. It accepts the valid/ready EFI-style result stream, deserializes one frame of 64 payload words plus 4 trailer words into a local buffer, and verifies the payload checksum carried in trailer word 0. It then holds the frame for random-access readout until the consumer acknowledges it. It sits between the PE array output and the result sink (scoreboard in simulation, host DMA in hardware).

## Interface
- DATA_W, 32, stream and buffer word width
- PAYLOAD_WORDS, 64, payload words per frame
- TRAILER_WORDS, 4, trailer words per frame; word 0 is the checksum
- CNT_W, 16, width of frame and error counters
- clock  in  1  single clock; all logic rising-edge
- resetn  in  1  asynchronous, active-low reset
- ovalid  in  1  upstream word valid
- oready  out  1  receiver can accept a word
- odata  in  DATA_W  upstream word
- frame_done  out  1  one-cycle pulse, frame captured
- frame_ok  out  1  checksum result of the held frame, valid from frame_done until the next frame starts
- rd_addr  in  $clog2(PAYLOAD_WORDS+TRAILER_WORDS)  buffer read address; payload at 0..63, trailer at 64..67
- rd_data  out  DATA_W  registered buffer read data
- frame_ack  in  1  consumer releases the held frame
- frame_cnt  out  CNT_W  frames captured, wraps
- err_cnt  out  CNT_W  frames with a checksum mismatch, saturates

## Operation
- States: PAYLOAD, TRAILER, HOLD. Reset state is PAYLOAD.
- A transfer occurs when ovalid && oready. Each transferred word is written to buffer[wcnt], and wcnt increments.
- PAYLOAD: oready=1. Each payload word is added to a DATA_W-bit running sum, wrapping mod 2^DATA_W. When word PAYLOAD_WORDS-1 transfers, go to TRAILER.
- TRAILER: oready=1. When trailer word 0 transfers, frame_ok is latched as (odata == sum). When word TRAILER_WORDS-1 transfers, go to HOLD; frame_done pulses on the next cycle; frame_cnt increments; err_cnt increments if !frame_ok, unless it is already 0xFFFF.
- HOLD: oready=0, and ovalid is ignored. frame_ack=1 causes the next state to be PAYLOAD, with wcnt=0 and sum=0. frame_ack outside HOLD is ignored.
- Reads are available in every state. rd_addr values ≥ PAYLOAD_WORDS+TRAILER_WORDS return 0.

## Timing
- Reset values: oready=0, frame_done=0, frame_ok=0, rd_data=0, frame_cnt=0, err_cnt=0, wcnt=0, sum=0.
- oready is registered. It rises on the first clock edge after resetn deasserts.
- Last trailer word accepted at edge N: state=HOLD, oready=0, and frame_done=1 all hold during cycle N+1. frame_done is 0 again at N+2.
- rd_data has 1-cycle latency: rd_addr sampled at edge N appears on rd_data after edge N.
- frame_ack sampled at edge N in HOLD: oready=1 after edge N, so the first word of the next frame can transfer at edge N+1.
- If frame_ack coincides with frame_done, the ack is honoured.
- Back-to-back throughput: 68 accepted cycles + 1 HOLD cycle minimum per frame.
- ovalid may drop mid-frame; wcnt and sum simply hold.
- Reset mid-frame discards the partial frame. The buffer contents are not cleared; only state, counters, and outputs reset.
- frame_cnt wraps 0xFFFF→0x0000. err_cnt stays at 0xFFFF once reached.

## Configuration
- PE_RX_CHECKSUM_EN defined: checksum accumulator and compare are present, and behaviour is as above.
- PE_RX_CHECKSUM_EN undefined: the sum logic is removed, frame_ok is forced to 1 at frame_done, and err_cnt is constant 0. Trailer word 0 is still stored in the buffer.

## Structure
- pe_types package holds:
  - the state enum pe_rx_state_t (PAYLOAD, TRAILER, HOLD);
  - the frame geometry constants PE_FRAME_PAYLOAD=64 and PE_FRAME_TRAILER=4, used as parameter defaults here and by the input driver;
  - the derived address width.
- One sub-module, pe_rx_buf: simple dual-port RAM of PAYLOAD_WORDS+TRAILER_WORDS × DATA_W, with a synchronous write port, a registered read port, and out-of-range reads returning 0.

## Test plan
- Payload words 0..63, trailer {0x000007E0, 1, 2, 3} → frame_done pulse; frame_ok=1; frame_cnt=1; err_cnt=0; rd_addr=10 gives 10; rd_addr=64 gives 0x7E0.
- Same frame with trailer word 0 = 0x000007E1 → frame_ok=0, err_cnt=1. With PE_RX_CHECKSUM_EN undefined → frame_ok=1, err_cnt=0.
- Second frame sent while the first is unacked → oready stays 0 and the buffer is unchanged; after frame_ack, the second frame captures and frame_cnt=2.
- Payload of 64×0xFFFFFFFF, trailer word 0 = 0xFFFFFFC0 → sum wraps correctly and frame_ok=1.
- ovalid toggled every other cycle → frame captured identically; frame_done occurs 1 cycle after the last transfer.
- resetn pulsed low after 30 payload words → oready=0 during reset; next complete frame of 0..63 gives frame_ok=1 and frame_cnt=1.

Source files
------------

// File: rtl/pe_types.sv
// Shared frame geometry and receive-state encoding for the PE array stream endpoints.
// Both the input driver and pe_rx_frame size themselves from these constants.
package pe_types;

  localparam int PE_FRAME_PAYLOAD = 64;
  localparam int PE_FRAME_TRAILER = 4;
  localparam int PE_FRAME_WORDS   = PE_FRAME_PAYLOAD + PE_FRAME_TRAILER;
  localparam int PE_FRAME_AW      = $clog2(PE_FRAME_WORDS);

  typedef enum logic [1:0] {
    PAYLOAD = 2'd0,
    TRAILER = 2'd1,
    HOLD    = 2'd2
  } pe_rx_state_t;

endpackage

// File: rtl/pe_rx_buf.sv
// Frame buffer: simple dual-port RAM, synchronous write, one-cycle registered read.
// Addresses at or beyond DEPTH read back as zero and are never written.
module pe_rx_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 68,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              waddr_ok, raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_V);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_V);

  // Storage is deliberately not reset: a reset discards the frame, not the data.
  always_ff @(posedge clock) begin
    if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (raddr_ok) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pe_rx_frame.sv
// PE array result receiver: captures payload+trailer into a buffer, holds it until frame_ack, stalls while holding.
// Checksum compare only when PE_RX_CHECKSUM_EN is defined; otherwise frame_ok=1 and err_cnt=0.
module pe_rx_frame
  import pe_types::*;
#(
  parameter int DATA_W        = 32,
  parameter int PAYLOAD_WORDS = PE_FRAME_PAYLOAD,
  parameter int TRAILER_WORDS = PE_FRAME_TRAILER,
  parameter int CNT_W         = 16
) (
  input  logic                                            clock,
  input  logic                                            resetn,
  input  logic                                            ovalid,
  output logic                                            oready,
  input  logic [DATA_W-1:0]                               odata,
  output logic                                            frame_done,
  output logic                                            frame_ok,
  input  logic [$clog2(PAYLOAD_WORDS+TRAILER_WORDS)-1:0]  rd_addr,
  output logic [DATA_W-1:0]                               rd_data,
  input  logic                                            frame_ack,
  output logic [CNT_W-1:0]                                frame_cnt,
  output logic [CNT_W-1:0]                                err_cnt
);

  localparam int DEPTH = PAYLOAD_WORDS + TRAILER_WORDS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0] LAST_PAY  = AW'(PAYLOAD_WORDS - 1);
  localparam logic [AW-1:0] TRAIL0    = AW'(PAYLOAD_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  pe_rx_state_t      state_q, state_d;
  logic [AW-1:0]     wcnt_q, wcnt_d;
  logic              oready_q, oready_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_ok_q, frame_ok_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              xfer;

`ifdef PE_RX_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
`endif

  assign xfer = ovalid && oready_q;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_cnt_d  = frame_cnt_q;
`ifdef PE_RX_CHECKSUM_EN
    sum_d        = sum_q;
    err_cnt_d    = err_cnt_q;
`endif

    case (state_q)
      PAYLOAD: begin
        if (xfer) begin
          wcnt_d = wcnt_q + AW'(1);
`ifdef PE_RX_CHECKSUM_EN
          sum_d  = sum_q + odata;
`endif
          if (wcnt_q == LAST_PAY) begin
            state_d = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (xfer) begin
          wcnt_d = wcnt_q + AW'(1);
          if (wcnt_q == TRAIL0) begin
`ifdef PE_RX_CHECKSUM_EN
            frame_ok_d = (odata == sum_q);
`else
            frame_ok_d = 1'b1;
`endif
          end
          if (wcnt_q == LAST_WORD) begin
            state_d      = HOLD;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
`ifdef PE_RX_CHECKSUM_EN
            // frame_ok_d already reflects this frame, even with a one-word trailer.
            if (!frame_ok_d && (err_cnt_q != '1)) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
`endif
          end
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_d = PAYLOAD;
          wcnt_d  = '0;
`ifdef PE_RX_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: begin
        state_d = PAYLOAD;
        wcnt_d  = '0;
      end
    endcase

    // Registered ready follows the next state, so the ack edge reopens the stream.
    oready_d = (state_d != HOLD);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= PAYLOAD;
      wcnt_q       <= '0;
      oready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef PE_RX_CHECKSUM_EN
      sum_q        <= '0;
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      oready_q     <= oready_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef PE_RX_CHECKSUM_EN
      sum_q        <= sum_d;
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  pe_rx_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clock  (clock),
    .resetn (resetn),
    .we     (xfer),
    .waddr  (wcnt_q),
    .wdata  (odata),
    .raddr  (rd_addr),
    .rdata  (rd_data)
  );

  assign oready     = oready_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_cnt  = frame_cnt_q;
`ifdef PE_RX_CHECKSUM_EN
  assign err_cnt    = err_cnt_q;
`else
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_pe_rx_frame.sv
// Directed bench for pe_rx_frame: capture, checksum, hold/ack, wrap sums, gapped input, mid-frame reset.
module tb_pe_rx_frame;

  logic        clock;
  logic        resetn;
  logic        ovalid;
  logic        oready;
  logic [31:0] odata;
  logic        frame_done;
  logic        frame_ok;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_ack;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

`ifdef PE_RX_CHECKSUM_EN
  localparam logic BAD_OK  = 1'b0;
  localparam int   BAD_ERR = 1;
`else
  localparam logic BAD_OK  = 1'b1;
  localparam int   BAD_ERR = 0;
`endif

  pe_rx_frame dut (
    .clock      (clock),
    .resetn     (resetn),
    .ovalid     (ovalid),
    .oready     (oready),
    .odata      (odata),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_ack  (frame_ack),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds the word until it transfers; returns #1 after the accepting edge.
  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    ovalid = 1'b1;
    odata  = d;
    while (oready !== 1'b1 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("send_ready", {31'd0, oready}, 32'd1);
    @(posedge clock);
    #1;
    ovalid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  // mode 0: word i, mode 1: all ones, mode 2: 100+i
  task automatic send_frame(input int mode, input logic [31:0] t0, input bit gaps);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      case (mode)
        1:       w = 32'hFFFF_FFFF;
        2:       w = 32'd100 + 32'(i);
        default: w = 32'(i);
      endcase
      send_word(w);
      if (gaps) idle();
    end
    send_word(t0);
    if (gaps) idle();
    send_word(32'd1);
    if (gaps) idle();
    send_word(32'd2);
    if (gaps) idle();
    send_word(32'd3);
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] exp, input string tag);
    rd_addr = a;
    @(posedge clock);
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(posedge clock);
    #1;
    frame_ack = 1'b0;
    chk("ack_oready", {31'd0, oready}, 32'd1);
  endtask

  task automatic done_checks(input logic ok, input int fcnt, input int ecnt, input string tag);
    chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
    chk({tag, "_hold_rdy"}, {31'd0, oready}, 32'd0);
    chk({tag, "_ok"}, {31'd0, frame_ok}, {31'd0, ok});
    chk({tag, "_fcnt"}, {16'd0, frame_cnt}, 32'(fcnt));
    chk({tag, "_ecnt"}, {16'd0, err_cnt}, 32'(ecnt));
  endtask

  initial begin
    resetn    = 1'b0;
    ovalid    = 1'b0;
    odata     = '0;
    rd_addr   = '0;
    frame_ack = 1'b0;
    repeat (3) idle();

    chk("rst_oready", {31'd0, oready}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_ok", {31'd0, frame_ok}, 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_ecnt", {16'd0, err_cnt}, 32'd0);

    resetn = 1'b1;
    idle();
    chk("first_oready", {31'd0, oready}, 32'd1);

    // Frame A: 0..63, correct checksum 0x7E0
    send_frame(0, 32'h0000_07E0, 1'b0);
    done_checks(1'b1, 1, 0, "a");
    idle();
    chk("a_done_low", {31'd0, frame_done}, 32'd0);
    rd(7'd10, 32'd10, "a_rd10");
    rd(7'd64, 32'h0000_07E0, "a_rd64");
    rd(7'd67, 32'd3, "a_rd67");
    rd(7'd68, 32'd0, "a_rd68_oob");
    rd(7'd127, 32'd0, "a_rd127_oob");

    // Upstream pushes while frame is held: must be stalled and not written
    ovalid = 1'b1;
    odata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("hold_stall", {31'd0, oready}, 32'd0);
    end
    ovalid = 1'b0;
    rd(7'd0, 32'd0, "hold_rd0");
    rd(7'd10, 32'd10, "hold_rd10");
    chk("hold_fcnt", {16'd0, frame_cnt}, 32'd1);

    // Frame B after ack: 100+i, sum = 6400+2016 = 0x20E0
    ack();
    send_frame(2, 32'h0000_20E0, 1'b0);
    done_checks(1'b1, 2, 0, "b");
    rd(7'd10, 32'd110, "b_rd10");

    // Frame C: bad checksum; ack coincides with frame_done
    ack();
    send_frame(0, 32'h0000_07E1, 1'b0);
    done_checks(BAD_OK, 3, BAD_ERR, "c");
    frame_ack = 1'b1;
    idle();
    frame_ack = 1'b0;
    chk("c_coinc_oready", {31'd0, oready}, 32'd1);
    chk("c_coinc_done_low", {31'd0, frame_done}, 32'd0);

    // Frame D: sum of 64 x 0xFFFFFFFF wraps to 0xFFFFFFC0
    send_frame(1, 32'hFFFF_FFC0, 1'b0);
    done_checks(1'b1, 4, BAD_ERR, "d");
    rd(7'd5, 32'hFFFF_FFFF, "d_rd5");

    // Frame E: ovalid every other cycle
    ack();
    send_frame(0, 32'h0000_07E0, 1'b1);
    done_checks(1'b1, 5, BAD_ERR, "e");
    rd(7'd63, 32'd63, "e_rd63");
    rd(7'd65, 32'd1, "e_rd65");

    // Reset after 30 payload words of a new frame
    ack();
    for (int i = 0; i < 30; i++) send_word(32'(i));
    resetn = 1'b0;
    #1;
    chk("mrst_oready", {31'd0, oready}, 32'd0);
    chk("mrst_fcnt", {16'd0, frame_cnt}, 32'd0);
    chk("mrst_ecnt", {16'd0, err_cnt}, 32'd0);
    chk("mrst_ok", {31'd0, frame_ok}, 32'd0);
    idle();
    chk("mrst_oready_held", {31'd0, oready}, 32'd0);
    resetn = 1'b1;
    rd(7'd40, 32'd40, "mrst_buf_kept");
    chk("mrst_oready_up", {31'd0, oready}, 32'd1);

    send_frame(0, 32'h0000_07E0, 1'b0);
    done_checks(1'b1, 1, 0, "f");
    rd(7'd64, 32'h0000_07E0, "f_rd64");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
